// File: rtl/scan_pkg.sv
// Shared definitions for the scan select generator.
//   state_t    : FSM encodings IDLE/ON/BLANK
//   NUM_POS    : number of decoder positions
//   SEL_W      : width of the position index
//   CNT_W      : width of the in-state cycle counter
//   first_set  : index of the lowest set bit in a position mask
package scan_pkg;

   localparam int NUM_POS = 4;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ON    = 2'b01,
      BLANK = 2'b10
   } state_t;

   // Returns 0 for an all-zero mask; callers only use it with a non-zero mask.
   function automatic logic [SEL_W-1:0] first_set(input logic [NUM_POS-1:0] m);
      logic [SEL_W-1:0] idx;
      idx = '0;
      // Descending scan so the lowest set bit is the last one written.
      for (int i = NUM_POS - 1; i >= 0; i--) begin
         if (m[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/scan_sel_gen_if.sv
// Control/output bundle between a scan controller and the select generator.
//   run         : 1 = scan, 0 = stop and blank
//   digit_mask  : positions taking part in the scan
//   enable      : active-low decoder enable
//   sel         : position index presented to the decoder
//   frame_done  : one-cycle pulse on wrap to the lowest enabled position
// master drives run/digit_mask; slave (the generator) drives the rest.
interface scan_sel_gen_if;
   import scan_pkg::*;

   logic               run;
   logic [NUM_POS-1:0] digit_mask;
   logic               enable;
   logic [SEL_W-1:0]   sel;
   logic               frame_done;

   modport master (
      output run, digit_mask,
      input  enable, sel, frame_done
   );

   modport slave (
      input  run, digit_mask,
      output enable, sel, frame_done
   );

endinterface

// File: rtl/scan_sel_gen_next_pos_sel.sv
// Combinational next-position search.
//   cur   : currently selected position
//   mask  : enabled positions
//   nxt   : lowest enabled position strictly above cur, else lowest enabled
//   wrap  : 1 when the search wrapped around to the lowest enabled position
module next_pos_sel
   import scan_pkg::*;
(
   input  logic [SEL_W-1:0]   cur,
   input  logic [NUM_POS-1:0] mask,
   output logic [SEL_W-1:0]   nxt,
   output logic               wrap
);

   always_comb begin
      nxt  = first_set(mask);
      wrap = 1'b1;
      // Descending priority search: the lowest qualifying index wins.
      for (int i = NUM_POS - 1; i >= 0; i--) begin
         if (mask[i] && (SEL_W'(i) > cur)) begin
            nxt  = SEL_W'(i);
            wrap = 1'b0;
         end
      end
   end

endmodule

// File: rtl/scan_sel_gen.sv
// Sequential select/enable generator feeding a 2-to-4 active-low decoder.
// Walks sel over the enabled positions, holding each one active (enable=0)
// for PRESCALE cycles followed by BLANK_CYCLES blanking cycles (enable=1).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of scan_sel_gen_if (run/digit_mask in,
//              enable/sel/frame_done out, all registered)
module scan_sel_gen
   import scan_pkg::*;
#(
   parameter int PRESCALE     = 4,   // 1..255
   parameter int BLANK_CYCLES = 1    // 0..255
)(
   input  logic           clk,
   input  logic           rst,
   scan_sel_gen_if.slave  bus
);

   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(PRESCALE - 1);
   // BLANK is unreachable when BLANK_CYCLES==0; clamp to keep the constant legal.
   localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] sel_q;
   logic             enable_q;
   logic             frame_done_q;

   logic [SEL_W-1:0] nxt_sel;
   logic             nxt_wrap;
   logic             stop;

   next_pos_sel u_next (
      .cur  (sel_q),
      .mask (bus.digit_mask),
      .nxt  (nxt_sel),
      .wrap (nxt_wrap)
   );

   // Dropping run or emptying the mask both abort the scan and blank the decoder.
   assign stop = !bus.run || (bus.digit_mask == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         sel_q        <= '0;
         enable_q     <= 1'b1;
         frame_done_q <= 1'b0;
         cnt          <= '0;
      end else begin
         frame_done_q <= 1'b0;
         case (state)
            IDLE: begin
               enable_q <= 1'b1;
               if (!stop) begin
                  state    <= ON;
                  enable_q <= 1'b0;
                  sel_q    <= first_set(bus.digit_mask);
                  cnt      <= '0;
               end
            end

            ON: begin
               if (stop) begin
                  state    <= IDLE;
                  enable_q <= 1'b1;
                  cnt      <= '0;
               end else if (cnt == ON_LAST) begin
                  cnt <= '0;
                  if (BLANK_CYCLES > 0) begin
                     state    <= BLANK;
                     enable_q <= 1'b1;
                  end else begin
                     // No blanking: hop straight to the next position.
                     sel_q        <= nxt_sel;
                     frame_done_q <= nxt_wrap;
                     enable_q     <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            BLANK: begin
               if (stop) begin
                  state    <= IDLE;
                  enable_q <= 1'b1;
                  cnt      <= '0;
               end else if (cnt == BLANK_LAST) begin
                  state        <= ON;
                  sel_q        <= nxt_sel;
                  frame_done_q <= nxt_wrap;
                  enable_q     <= 1'b0;
                  cnt          <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               enable_q <= 1'b1;
               cnt      <= '0;
            end
         endcase
      end
   end

   assign bus.enable     = enable_q;
   assign bus.sel        = sel_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Scoreboard bench: the stimulus process pushes the hand-derived expected
// outputs for each driven cycle; the monitor pops one entry per clock and
// compares it against the DUT outputs and the decoded data lines.
module tb_scan_sel_gen;
   import scan_pkg::*;

   typedef struct {
      bit         dut;
      logic       en;
      logic [1:0] sel;
      logic       fd;
      logic [3:0] data;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b1;
   logic [3:0] mask = 4'hF;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   scan_sel_gen_if if0 ();
   scan_sel_gen_if if1 ();

   assign if0.run        = run;
   assign if0.digit_mask = mask;
   assign if1.run        = run;
   assign if1.digit_mask = mask;

   scan_sel_gen #(.PRESCALE(4), .BLANK_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   scan_sel_gen #(.PRESCALE(4), .BLANK_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   // Downstream 2-to-4 active-low decoder.
   function automatic logic [3:0] dec(input logic en, input logic [1:0] s);
      logic [3:0] one;
      one = 4'b0001;
      return en ? 4'b1111 : ~(one << s);
   endfunction

   logic [3:0] data0, data1;
   assign data0 = dec(if0.enable, if0.sel);
   assign data1 = dec(if1.enable, if1.sel);

   task automatic step(input logic r, input logic ru, input logic [3:0] m,
                       input bit d, input logic en, input logic [1:0] s,
                       input logic fd, input string tag);
      exp_t e;
      @(negedge clk);
      rst  = r;
      run  = ru;
      mask = m;
      e.dut = d; e.en = en; e.sel = s; e.fd = fd; e.data = dec(en, s); e.tag = tag;
      q.push_back(e);
   endtask

   // Monitor: one output sample per clock, just after the edge.
   initial begin
      exp_t e;
      logic [7:0] got, want;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            want = {e.en, e.sel, e.fd, e.data};
            got  = e.dut ? {if1.enable, if1.sel, if1.frame_done, data1}
                         : {if0.enable, if0.sel, if0.frame_done, data0};
            checks++;
            if (got !== want) begin
               failures++;
               $display("FAIL %s: got en/sel/fd/data=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                        e.tag, got[7], got[6:5], got[4], got[3:0],
                        want[7], want[6:5], want[4], want[3:0]);
            end
         end
      end
   end

   initial begin
      // Reset held two cycles with run asserted.
      step(1, 1, 4'hF, 0, 1, 0, 0, "reset0");
      step(1, 1, 4'hF, 1, 1, 0, 0, "reset1");

      // Full scan, all positions: 4 active + 1 blank per position.
      for (int pass = 0; pass < 2; pass++) begin
         for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++)
               step(0, 1, 4'hF, 0, 0, 2'(p), (pass == 1 && p == 0 && k == 0), "full_on");
            step(0, 1, 4'hF, 0, 1, 2'(p), 0, "full_blank");
         end
      end
      step(0, 1, 4'hF, 0, 0, 0, 1, "full_wrap");

      // Stop from ON, then sparse mask 1010.
      step(0, 0, 4'hF, 0, 1, 0, 0, "stop_on");
      for (int pass = 0; pass < 2; pass++) begin
         for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 4; k++)
               step(0, 1, 4'hA, 0, 0, (j == 0) ? 2'd1 : 2'd3,
                    (pass == 1 && j == 0 && k == 0), "sparse_on");
            step(0, 1, 4'hA, 0, 1, (j == 0) ? 2'd1 : 2'd3, 0, "sparse_blank");
         end
      end
      step(0, 1, 4'hA, 0, 0, 1, 1, "sparse_wrap");

      // Stop in the middle of sel=3's active period, then restart.
      for (int k = 0; k < 3; k++) step(0, 1, 4'hA, 0, 0, 1, 0, "pre_stop_on");
      step(0, 1, 4'hA, 0, 1, 1, 0, "pre_stop_blank");
      step(0, 1, 4'hA, 0, 0, 3, 0, "pre_stop_sel3");
      step(0, 1, 4'hA, 0, 0, 3, 0, "pre_stop_sel3b");
      step(0, 0, 4'hA, 0, 1, 3, 0, "stop_hold");
      step(0, 0, 4'hA, 0, 1, 3, 0, "idle_hold");
      step(0, 1, 4'hA, 0, 0, 1, 0, "restart");

      // Mask collapses during BLANK.
      for (int k = 0; k < 3; k++) step(0, 1, 4'hA, 0, 0, 1, 0, "collapse_on");
      step(0, 1, 4'hA, 0, 1, 1, 0, "collapse_blank");
      step(0, 1, 4'h0, 0, 1, 1, 0, "collapse_idle");
      step(0, 1, 4'h0, 0, 1, 1, 0, "idle_mask0");
      step(0, 1, 4'h8, 0, 0, 3, 0, "start_sel3");
      step(0, 1, 4'h8, 0, 0, 3, 0, "on_sel3");

      // Reset while ON.
      step(1, 1, 4'h8, 0, 1, 0, 0, "reset_mid");

      // Active position's own bit clears: it finishes, then is skipped.
      step(0, 1, 4'hF, 0, 0, 0, 0, "clr_start");
      for (int k = 0; k < 3; k++) step(0, 1, 4'hE, 0, 0, 0, 0, "clr_finish");
      step(0, 1, 4'hE, 0, 1, 0, 0, "clr_blank");
      step(0, 1, 4'hE, 0, 0, 1, 0, "clr_skip");

      // Single position, no blanking (second instance).
      step(1, 0, 4'h4, 1, 1, 0, 0, "single_reset");
      step(0, 1, 4'h4, 1, 0, 2, 0, "single_start");
      for (int k = 0; k < 3; k++) step(0, 1, 4'h4, 1, 0, 2, 0, "single_on");
      for (int r = 0; r < 3; r++) begin
         step(0, 1, 4'h4, 1, 0, 2, 1, "single_wrap");
         for (int k = 0; k < 3; k++) step(0, 1, 4'h4, 1, 0, 2, 0, "single_on");
      end

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
